// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory controller
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MERGE = 2'd2
    } dmem_state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int MASK_UNSIGNED_BIT = 2;

    // Size code 2'b11 is treated as a word everywhere.
    function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_B:  dmem_misaligned = 1'b0;
            SIZE_H:  dmem_misaligned = offset[0];
            default: dmem_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte/half lane extract with extension, and lane merge for sub-word stores
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] store_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Half lanes use only offset[1], so a misaligned half is forced onto its aligned lane.
    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = word_i;
        merge_o  = word_i;
        case (size_i)
            SIZE_B: begin
                load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
                merge_o[{offset_i, 3'b000} +: 8] = store_i[7:0];
            end
            SIZE_H: begin
                load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
                if (offset_i[1]) merge_o[31:16] = store_i;
                else             merge_o[15:0]  = store_i;
            end
            default: begin
                load_o  = word_i;
                merge_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU data memory controller (optional misaligned trap: DMEM_MISALIGN_TRAP_EN)
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic              req_read_i,
    input  logic              req_write_i,
    input  logic [2:0]        req_mask_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              fault_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    dmem_state_e     state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [2:0]      mask_q, mask_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            fault_load_q, fault_load_d;

    logic [31:0]     load_data;
    logic [31:0]     merged_data;
    logic            misalign_req;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^req_addr_i[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_req = dmem_misaligned(req_mask_i[1:0], req_addr_i[1:0]);
`else
    assign misalign_req = 1'b0;
`endif

    dmem_lane_align u_lane (
        .word_i     (mem_rdata_i),
        .offset_i   (addr_q[1:0]),
        .size_i     (mask_q[1:0]),
        .unsigned_i (mask_q[MASK_UNSIGNED_BIT]),
        .store_i    (wdata_q),
        .load_o     (load_data),
        .merge_o    (merged_data)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        mask_d        = mask_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        fault_load_d  = fault_load_q;
        stall_o       = 1'b0;
        mem_we_o      = 1'b0;
        mem_wdata_o   = merged_data;
        mem_addr_o    = addr_q[ADDR_W+1:2];
        rdata_o       = rdata_q;
        rdata_valid_o = 1'b0;
        fault_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_read_i || req_write_i) begin
                    addr_d     = req_addr_i[ADDR_W+1:0];
                    mask_d     = req_mask_i;
                    wdata_d    = req_wdata_i[15:0];
                    mem_addr_o = req_addr_i[ADDR_W+1:2];
                    fault_o    = misalign_req;
                    if (req_write_i) begin
                        if (misalign_req) begin
                            state_d = IDLE;
                        end else if (req_mask_i[1:0] == SIZE_B || req_mask_i[1:0] == SIZE_H) begin
                            stall_o = 1'b1;
                            state_d = MERGE;
                        end else begin
                            mem_we_o    = 1'b1;
                            mem_wdata_o = req_wdata_i;
                        end
                    end else begin
                        stall_o      = 1'b1;
                        fault_load_d = misalign_req;
                        state_d      = LOAD;
                    end
                end
            end
            LOAD: begin
                rdata_d       = fault_load_q ? 32'd0 : load_data;
                rdata_o       = rdata_d;
                rdata_valid_o = 1'b1;
                fault_load_d  = 1'b0;
                state_d       = IDLE;
            end
            MERGE: begin
                mem_we_o = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset must silence the request-driven IDLE paths as well as the state-driven ones.
        if (reset_i) begin
            stall_o       = 1'b0;
            mem_we_o      = 1'b0;
            rdata_valid_o = 1'b0;
            fault_o       = 1'b0;
            rdata_o       = 32'd0;
            mem_addr_o    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            fault_load_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            fault_load_q <= fault_load_d;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_read_i;
    logic        req_write_i;
    logic [2:0]  req_mask_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        fault_o;
    logic [9:0]  mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] ram [0:1023];
    logic        init_we;
    logic [9:0]  init_addr;
    logic [31:0] init_data;

    int passed = 0;
    int total  = 0;

    data_mem_ctrl #(.ADDR_W(10)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_read_i    (req_read_i),
        .req_write_i   (req_write_i),
        .req_mask_i    (req_mask_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .fault_o       (fault_o),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous RAM: read data appears one cycle after the address.
    always @(posedge clk_i) begin
        if (init_we)       ram[init_addr]  <= init_data;
        else if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= ram[mem_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] mask);
        req_read_i  = rd;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_mask_i  = mask;
        #1;
    endtask

    task automatic idle_req();
        req_read_i  = 1'b0;
        req_write_i = 1'b0;
        #1;
    endtask

    initial begin
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;
        reset_i   = 1'b1;
        req(1'b1, 1'b0, 32'h0000_0013, 32'h0, 3'b000);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_valid", {31'd0, rdata_valid_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_addr", {22'd0, mem_addr_o}, 32'd0);
        idle_req();
        tick();
        reset_i   = 1'b0;
        init_we   = 1'b1;
        init_addr = 10'd4;
        init_data = 32'h8899_AABB;
        tick();
        init_addr = 10'd8;
        init_data = 32'h0;
        tick();
        init_we = 1'b0;

        // LB at 0x11
        req(1'b1, 1'b0, 32'h0000_0011, 32'h0, 3'b000);
        chk("lb_stall", {31'd0, stall_o}, 32'd1);
        chk("lb_addr", {22'd0, mem_addr_o}, 32'd4);
        chk("lb_we", {31'd0, mem_we_o}, 32'd0);
        tick();
        idle_req();
        chk("lb_stall_load", {31'd0, stall_o}, 32'd0);
        chk("lb_valid", {31'd0, rdata_valid_o}, 32'd1);
        chk("lb_rdata", rdata_o, 32'hFFFF_FFAA);
        tick();
        chk("lb_valid_drop", {31'd0, rdata_valid_o}, 32'd0);
        chk("lb_rdata_hold", rdata_o, 32'hFFFF_FFAA);

        // LHU at 0x12; a store presented during LOAD must be ignored
        req(1'b1, 1'b0, 32'h0000_0012, 32'h0, 3'b101);
        chk("lhu_stall", {31'd0, stall_o}, 32'd1);
        tick();
        req(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 3'b010);
        chk("lhu_rdata", rdata_o, 32'h0000_8899);
        chk("lhu_valid", {31'd0, rdata_valid_o}, 32'd1);
        chk("busy_req_no_we", {31'd0, mem_we_o}, 32'd0);
        tick();
        idle_req();

        // SB 0x5C at 0x13
        req(1'b0, 1'b1, 32'h0000_0013, 32'h0000_005C, 3'b000);
        chk("sb_stall", {31'd0, stall_o}, 32'd1);
        chk("sb_we_accept", {31'd0, mem_we_o}, 32'd0);
        tick();
        idle_req();
        chk("sb_we_merge", {31'd0, mem_we_o}, 32'd1);
        chk("sb_stall_merge", {31'd0, stall_o}, 32'd0);
        chk("sb_wdata", mem_wdata_o, 32'h5C99_AABB);
        chk("sb_addr", {22'd0, mem_addr_o}, 32'd4);
        tick();
        chk("sb_we_after", {31'd0, mem_we_o}, 32'd0);
        chk("sb_ram", ram[4], 32'h5C99_AABB);

        // SW 0xDEADBEEF at 0x20
        req(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 3'b010);
        chk("sw_we", {31'd0, mem_we_o}, 32'd1);
        chk("sw_stall", {31'd0, stall_o}, 32'd0);
        chk("sw_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("sw_addr", {22'd0, mem_addr_o}, 32'd8);
        tick();
        idle_req();
        chk("sw_stall_next", {31'd0, stall_o}, 32'd0);
        chk("sw_ram", ram[8], 32'hDEAD_BEEF);

        // LH at 0x21 (misaligned)
        req(1'b1, 1'b0, 32'h0000_0021, 32'h0, 3'b001);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lh_mis_fault", {31'd0, fault_o}, 32'd1);
`else
        chk("lh_mis_fault", {31'd0, fault_o}, 32'd0);
`endif
        tick();
        idle_req();
        chk("lh_mis_fault_drop", {31'd0, fault_o}, 32'd0);
        chk("lh_mis_valid", {31'd0, rdata_valid_o}, 32'd1);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lh_mis_rdata", rdata_o, 32'h0000_0000);
`else
        chk("lh_mis_rdata", rdata_o, 32'hFFFF_BEEF);
`endif
        tick();

        // Read and write together: write wins, no load follows
        req(1'b1, 1'b1, 32'h0000_0010, 32'h1122_3344, 3'b010);
        chk("rw_we", {31'd0, mem_we_o}, 32'd1);
        chk("rw_stall", {31'd0, stall_o}, 32'd0);
        tick();
        idle_req();
        chk("rw_no_valid", {31'd0, rdata_valid_o}, 32'd0);
        chk("rw_ram", ram[4], 32'h1122_3344);

        // SH at 0x12 aborted by reset in MERGE
        req(1'b0, 1'b1, 32'h0000_0012, 32'h0000_CAFE, 3'b001);
        tick();
        idle_req();
        chk("sh_in_merge", {31'd0, mem_we_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        chk("mrst_we", {31'd0, mem_we_o}, 32'd0);
        chk("mrst_stall", {31'd0, stall_o}, 32'd0);
        chk("mrst_valid", {31'd0, rdata_valid_o}, 32'd0);
        chk("mrst_fault", {31'd0, fault_o}, 32'd0);
        chk("mrst_rdata", rdata_o, 32'd0);
        chk("mrst_addr", {22'd0, mem_addr_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        chk("mrst_ram", ram[4], 32'h1122_3344);
        chk("mrst_idle_we", {31'd0, mem_we_o}, 32'd0);

        // State is IDLE: a fresh LBU at 0x13 is accepted at once
        req(1'b1, 1'b0, 32'h0000_0013, 32'h0, 3'b100);
        chk("post_rst_stall", {31'd0, stall_o}, 32'd1);
        tick();
        idle_req();
        chk("lbu_rdata", rdata_o, 32'h0000_0011);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
